// File: rtl/wall_map.sv
// Destructible wall bitmap: VGA read port, game query/destroy port and arena builder.
// Optional armor (two hits per interior wall) is enabled with `define WALL_ARMOR_EN.
module wall_map #(
    parameter int WIDTH       = 64,
    parameter int GAME_HEIGHT = 44
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [5:0] i_vga_x,
    input  logic [5:0] i_vga_y,
    output logic       o_is_wall,
    input  logic       i_req_valid,
    input  logic       i_req_op,
    input  logic [5:0] i_req_x,
    input  logic [5:0] i_req_y,
    output logic       o_req_ready,
    output logic       o_rsp_valid,
    output logic       o_rsp_wall,
    output logic       o_init_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    localparam logic [5:0] LAST_ROW = 6'(GAME_HEIGHT - 1);

    state_t           state_r, state_s;
    logic [5:0]       row_r, row_s;
    logic [WIDTH-1:0] map_r [GAME_HEIGHT];

    logic       is_wall_r, ready_r, rsp_valid_r, rsp_wall_r;
    logic       vga_in_range_s, req_in_range_s, req_border_s;
    logic [5:0] vga_y_idx_s, req_y_idx_s;
    logic       vga_bit_s, cell_s, accept_s, wr_ok_s, clear_s;

    function automatic logic in_range(input int x, input int y);
        return (x < WIDTH) && (y < GAME_HEIGHT);
    endfunction

    function automatic logic is_border(input int x, input int y);
        return (x == 0) || (x == WIDTH - 1) || (y == 0) || (y == GAME_HEIGHT - 1);
    endfunction

    // Row built MSB first by shifting, so bit x holds cell (x, y).
    function automatic logic [WIDTH-1:0] row_pattern(input logic [5:0] y);
        logic [WIDTH-1:0] p;
        int               yy;
        logic             interior;
        p  = '0;
        yy = int'(y);
        for (int x = WIDTH - 1; x >= 0; x--) begin
            interior = ((x % 8) == 4) && ((yy % 8) >= 2) && ((yy % 8) <= 5) &&
                       (x >= 8) && (x < WIDTH - 8);
            p = {p[WIDTH-2:0], is_border(x, yy) || interior};
        end
        return p;
    endfunction

    // FSM state and row counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            row_r   <= 6'd0;
        end else begin
            state_r <= state_s;
            row_r   <= row_s;
        end
    end

    // Next-state logic; a start pulse always restarts the build at row 0.
    always_comb begin
        state_s = state_r;
        row_s   = row_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_s = ST_LOAD;
                    row_s   = 6'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (i_start) begin
                    row_s = 6'd0;
                end else if (row_r == LAST_ROW) begin
                    state_s = ST_READY;
                    row_s   = 6'd0;
                end else begin
                    row_s = row_r + 6'd1;
                end
            end
            ST_READY: begin
                if (i_start) begin
                    state_s = ST_LOAD;
                    row_s   = 6'd0;
                end else begin
                    state_s = ST_READY;
                end
            end
            default: begin
                state_s = ST_IDLE;
                row_s   = 6'd0;
            end
        endcase
    end

    // Address decode for both ports; out-of-range rows are steered to row 0 and masked.
    always_comb begin
        vga_in_range_s = in_range(int'(i_vga_x), int'(i_vga_y));
        vga_y_idx_s    = vga_in_range_s ? i_vga_y : 6'd0;
        vga_bit_s      = vga_in_range_s ? map_r[vga_y_idx_s][i_vga_x] : 1'b1;
        req_in_range_s = in_range(int'(i_req_x), int'(i_req_y));
        req_border_s   = is_border(int'(i_req_x), int'(i_req_y));
        req_y_idx_s    = req_in_range_s ? i_req_y : 6'd0;
        cell_s         = req_in_range_s ? map_r[req_y_idx_s][i_req_x] : 1'b1;
        accept_s       = i_req_valid && ready_r;
        wr_ok_s        = accept_s && i_req_op && req_in_range_s && !req_border_s && !i_start;
    end

`ifdef WALL_ARMOR_EN
    logic [WIDTH-1:0] damage_r [GAME_HEIGHT];
    logic             dmg_cell_s, dmg_set_s;

    // A wall must be hit once to become damaged before a second hit removes it.
    always_comb begin
        dmg_cell_s = damage_r[req_y_idx_s][i_req_x];
        clear_s    = wr_ok_s && cell_s && dmg_cell_s;
        dmg_set_s  = wr_ok_s && cell_s && !dmg_cell_s;
    end

    // Damage array: cleared row by row alongside the arena build.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            damage_r <= '{default: '0};
        end else if (state_r == ST_LOAD) begin
            damage_r[row_r] <= '0;
        end else if (clear_s) begin
            damage_r[req_y_idx_s][i_req_x] <= 1'b0;
        end else if (dmg_set_s) begin
            damage_r[req_y_idx_s][i_req_x] <= 1'b1;
        end
    end
`else
    // Without armor, a destroy on a wall clears it immediately.
    always_comb begin
        clear_s = wr_ok_s && cell_s;
    end
`endif

    // Wall bitmap: LOAD owns the map, otherwise game destroys clear single cells.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map_r <= '{default: '0};
        end else if (state_r == ST_LOAD) begin
            map_r[row_r] <= row_pattern(row_r);
        end else if (clear_s) begin
            map_r[req_y_idx_s][i_req_x] <= 1'b0;
        end
    end

    // Registered outputs; ready tracks the READY state it will be in after this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_wall_r   <= 1'b0;
            ready_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_wall_r  <= 1'b0;
        end else begin
            is_wall_r   <= vga_bit_s;
            ready_r     <= (state_s == ST_READY);
            rsp_valid_r <= accept_s;
            rsp_wall_r  <= accept_s ? cell_s : rsp_wall_r;
        end
    end

    assign o_is_wall   = is_wall_r;
    assign o_req_ready = ready_r;
    assign o_init_done = ready_r;
    assign o_rsp_valid = rsp_valid_r;
    assign o_rsp_wall  = rsp_wall_r;

endmodule
